multicycle_mem_responder: RTL and testbench

Memory-side responder for the multicycle core's unified instruction/data port. It accepts one read or write request at a time over a valid/ready handshake and models a configurable access latency. It performs the byte-masked access into an internal word-addressed RAM, then holds the response until the core takes it. It replaces the zero-latency memory model so that fetch and load/store states can be exercised against wait states.

---
 rtl/mem_responder_pkg.sv | 11 +
 rtl/mem_responder_ram.sv | 24 ++
 rtl/multicycle_mem_responder.sv | 84 ++++++++
 tb/tb_multicycle_mem_responder.sv | 135 +++++++++++++
 4 files changed

// File: rtl/mem_responder_pkg.sv
// mem_responder_pkg: shared types and constants for the multicycle memory responder
package mem_responder_pkg;
   localparam int LAT_W = 4;
   typedef enum logic [1:0] {IDLE, BUSY, RESP} state_e;
   typedef struct packed {
      logic        write;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [3:0]  wmask;
   } req_t;
endpackage

// File: rtl/mem_responder_ram.sv
// mem_responder_ram: single-port byte-masked synchronous RAM, 2^ADDR_WIDTH x 32
module mem_responder_ram #(
   parameter int ADDR_WIDTH = 10
) (
   input  logic                  clock,
   input  logic                  en,
   input  logic                  we,
   input  logic [3:0]            wmask,
   input  logic [ADDR_WIDTH-1:0] addr,
   input  logic [31:0]           wdata,
   output logic [31:0]           rdata
);
   logic [31:0] mem [2**ADDR_WIDTH];
   logic [31:0] rdata_q, rdata_d;
   // read data register only moves on an enabled read so it stays stable while the response waits
   always_comb rdata_d = (en && !we) ? mem[addr] : rdata_q;
   // registered read data and per-lane masked writes
   always_ff @(posedge clock) begin
      rdata_q <= rdata_d;
      for (int i = 0; i < 4; i++)
         if (en && we && wmask[i]) mem[addr][8*i +: 8] <= wdata[8*i +: 8];
   end
   assign rdata = rdata_q;
endmodule

// File: rtl/multicycle_mem_responder.sv
// multicycle_mem_responder: latency-modelling memory responder; MEM_RESPONDER_ERROR_EN enables fault reporting
module multicycle_mem_responder
   import mem_responder_pkg::*;
#(
   parameter int          LATENCY    = 2,
   parameter int          ADDR_WIDTH = 10,
   parameter logic [31:0] BASE_ADDR  = 32'h0000_0000
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_write,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wdata,
   input  logic [3:0]  req_wmask,
   output logic        resp_valid,
   input  logic        resp_ready,
   output logic [31:0] resp_rdata,
   output logic        resp_error
);
   state_e           state_q, state_d;
   logic [LAT_W-1:0] cnt_q, cnt_d;
   req_t             req_q, req_d;
   logic             err_q, err_d;
   logic             acc_err, ram_en;
   logic [31:0]      ram_rdata;
`ifdef MEM_RESPONDER_ERROR_EN
   assign acc_err = (req_q.addr[1:0] != 2'b00) || (((req_q.addr - BASE_ADDR) >> (ADDR_WIDTH + 2)) != 32'd0);
`else
   assign acc_err = 1'b0;
`endif
   // next-state: accept in IDLE, count down in BUSY, access on the last BUSY cycle, hold in RESP
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      req_d   = req_q;
      err_d   = err_q;
      ram_en  = 1'b0;
      case (state_q)
         IDLE: if (req_valid) begin
            req_d   = '{write: req_write, addr: req_addr, wdata: req_wdata, wmask: req_wmask};
            cnt_d   = LAT_W'(LATENCY - 1);
            state_d = BUSY;
         end
         BUSY: if (cnt_q == '0) begin
            ram_en  = !acc_err;
            err_d   = acc_err;
            state_d = RESP;
         end else begin
            cnt_d = cnt_q - LAT_W'(1);
         end
         RESP: if (resp_ready) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end
   // state, counter and captured request; reset drops any pending access
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         req_q   <= '0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         req_q   <= req_d;
         err_q   <= err_d;
      end
   end
   mem_responder_ram #(.ADDR_WIDTH(ADDR_WIDTH)) u_ram (
      .clock (clock),
      .en    (ram_en),
      .we    (req_q.write),
      .wmask (req_q.wmask),
      .addr  (ADDR_WIDTH'((req_q.addr - BASE_ADDR) >> 2)),
      .wdata (req_q.wdata),
      .rdata (ram_rdata)
   );
   assign req_ready  = state_q == IDLE;
   assign resp_valid = state_q == RESP;
   assign resp_error = resp_valid && err_q;
   assign resp_rdata = (resp_valid && !req_q.write && !err_q) ? ram_rdata : 32'd0;
endmodule

// File: tb/tb_multicycle_mem_responder.sv
// tb_multicycle_mem_responder: randomized self-checking bench against a word-array reference model
module tb_multicycle_mem_responder;
   localparam int          LAT  = 2;
   localparam int          AW   = 10;
   localparam logic [31:0] BASE = 32'h0000_0000;
   logic        clock = 1'b0, reset = 1'b1;
   logic        req_valid = 1'b0, req_write = 1'b0, resp_ready = 1'b0;
   logic [31:0] req_addr = '0, req_wdata = '0;
   logic [3:0]  req_wmask = '0;
   logic        req_ready, resp_valid, resp_error;
   logic [31:0] resp_rdata;
   int          checks = 0, errors = 0;
   logic [31:0] model [int];
   logic [31:0] rd;
   logic        er;
   always #5 clock = ~clock;
   multicycle_mem_responder #(.LATENCY(LAT), .ADDR_WIDTH(AW), .BASE_ADDR(BASE)) dut (
      .clock(clock), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
      .req_write(req_write), .req_addr(req_addr), .req_wdata(req_wdata), .req_wmask(req_wmask),
      .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_rdata(resp_rdata), .resp_error(resp_error)
   );
   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %h expected %h", tag, got, exp);
      end
   endtask
   function automatic logic model_err(input logic [31:0] a);
`ifdef MEM_RESPONDER_ERROR_EN
      return (a % 4 != 0) || ((a - BASE) >= 32'(4 * (1 << AW)));
`else
      return 1'b0;
`endif
   endfunction
   function automatic int model_idx(input logic [31:0] a);
      return int'(((a - BASE) / 4) % (1 << AW));
   endfunction
   task automatic xact(input logic w, input logic [31:0] a, input logic [31:0] d, input logic [3:0] m,
                       input int hold, output logic [31:0] rdo, output logic ero);
      int k, idx;
      logic e;
      logic [31:0] exp, cur;
      idx = model_idx(a);
      e   = model_err(a);
      cur = model.exists(idx) ? model[idx] : 32'd0;
      exp = (e || w) ? 32'd0 : cur;
      @(negedge clock);
      check("ready_idle", req_ready, 1);
      req_valid = 1'b1; req_write = w; req_addr = a; req_wdata = d; req_wmask = m;
      resp_ready = (hold == 0);
      @(posedge clock);
      @(negedge clock);
      req_valid = 1'($urandom_range(0, 1)); req_write = 1'b1;
      req_addr = BASE + 4 * $urandom_range(0, 63); req_wdata = $urandom; req_wmask = 4'hF;
      k = 0;
      while (!resp_valid && k < 40) begin
         check("busy_ready", req_ready, 0);
         @(negedge clock);
         k++;
      end
      check("latency", k, LAT);
      rdo = resp_rdata;
      ero = resp_error;
      check("rdata", rdo, exp);
      check("error", ero, e);
      repeat (hold) begin
         @(negedge clock);
         check("hold_valid", resp_valid, 1);
         check("hold_rdata", resp_rdata, rdo);
         check("hold_ready", req_ready, 0);
      end
      resp_ready = 1'b1;
      req_valid  = 1'b0;
      @(negedge clock);
      check("done_valid", resp_valid, 0);
      check("done_ready", req_ready, 1);
      resp_ready = 1'b0;
      if (w && !e) begin
         for (int i = 0; i < 4; i++) if (m[i]) cur[8*i +: 8] = d[8*i +: 8];
         model[idx] = cur;
      end
   endtask
   initial begin
      req_valid = 1'b1; req_write = 1'b1; req_addr = BASE; req_wdata = 32'hFFFF_FFFF; req_wmask = 4'hF;
      repeat (3) @(negedge clock);
      check("rst_ready", req_ready, 1);
      check("rst_valid", resp_valid, 0);
      check("rst_rdata", resp_rdata, 0);
      check("rst_error", resp_error, 0);
      reset = 1'b0; req_valid = 1'b0;
      @(negedge clock);
      check("post_rst_ready", req_ready, 1);
      for (int i = 0; i < 64; i++) xact(1'b1, BASE + 4 * i, $urandom, 4'hF, 0, rd, er);
      xact(1'b1, BASE + 32'h10, 32'hDEAD_BEEF, 4'hF, 0, rd, er);
      xact(1'b0, BASE + 32'h10, 32'h0, 4'h0, 0, rd, er);
      check("read_10", rd, 32'hDEAD_BEEF);
      xact(1'b1, BASE + 32'h20, 32'h1122_3344, 4'hF, 0, rd, er);
      xact(1'b1, BASE + 32'h20, 32'hAABB_CCDD, 4'b0101, 1, rd, er);
      xact(1'b0, BASE + 32'h20, 32'h0, 4'hF, 5, rd, er);
      check("mask_20", rd, 32'h11BB_33DD);
      xact(1'b1, BASE + 32'h30, 32'h0BAD_F00D, 4'hF, 0, rd, er);
      @(negedge clock);
      req_valid = 1'b1; req_write = 1'b1; req_addr = BASE + 32'h30; req_wdata = 32'h5555_AAAA; req_wmask = 4'hF;
      @(posedge clock);
      @(negedge clock);
      req_valid = 1'b0;
      reset = 1'b1;
      #1;
      check("midrst_ready", req_ready, 1);
      check("midrst_valid", resp_valid, 0);
      @(negedge clock);
      reset = 1'b0;
      xact(1'b0, BASE + 32'h30, 32'h0, 4'h0, 0, rd, er);
      check("midrst_keep", rd, 32'h0BAD_F00D);
`ifdef MEM_RESPONDER_ERROR_EN
      xact(1'b0, BASE + 32'h13, 32'h0, 4'h0, 0, rd, er);
      check("misalign_err", er, 1);
      xact(1'b0, BASE + 32'h1000, 32'h0, 4'h0, 0, rd, er);
      check("range_err", er, 1);
`else
      xact(1'b0, BASE + 32'h1010, 32'h0, 4'h0, 0, rd, er);
      check("alias_1010", rd, 32'hDEAD_BEEF);
`endif
      for (int n = 0; n < 200; n++) begin
         logic [31:0] a;
         a = BASE + 4 * $urandom_range(0, 63);
         if ($urandom_range(0, 3) == 0) a = a + 32'h1000 * $urandom_range(1, 3);
         if ($urandom_range(0, 5) == 0) a = a + $urandom_range(1, 3);
         xact(1'($urandom_range(0, 1)), a, $urandom, 4'($urandom_range(0, 15)), $urandom_range(0, 3), rd, er);
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
